// File: rtl/target_resetter_multi.sv
// ---------------------------------------------------------------------------
// target_resetter_multi
//
// Multi-channel target reset driver on the clk_usb host register bus.
// Every channel drives one reset pin. In level mode the pin follows a
// host-written level bit. In pulse mode a host "fire" starts a self-timed
// pulse of `width` clk_usb cycles. A per-channel polarity bit inverts the
// pin for active-low targets.
//
// State table (per channel)
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | no pulse running; cnt is 0
//   S_PULSE | pulse running; cnt holds the remaining cycles (>= 1)
//
// Ports
//   clk_usb        in   1       sole clock
//   reset          in   1       synchronous, active-low reset
//   reg_cmd        in   8       command code
//   reg_bytecount  in   16      byte index within the current command
//   reg_data_in    in   8       write data byte
//   reg_data_out   out  8       read data byte (combinational)
//   reg_read       in   1       read strobe
//   reg_write      in   1       write strobe, one byte per asserted cycle
//   target_reset   out  NUM_CH  registered reset pins
//   pulse_busy     out  NUM_CH  registered, 1 while the channel pulses
// ---------------------------------------------------------------------------
module target_resetter_multi #(
    parameter int         NUM_CH        = 4,
    parameter int         CNT_W         = 24,
    parameter int         DEFAULT_WIDTH = 1000,
    parameter logic [7:0] CMD_LEVEL     = 8'h30,
    parameter logic [7:0] CMD_MODE      = 8'h31,
    parameter logic [7:0] CMD_POLARITY  = 8'h32,
    parameter logic [7:0] CMD_WIDTH     = 8'h33,
    parameter logic [7:0] CMD_FIRE      = 8'h34
) (
    input  logic              clk_usb,
    input  logic              reset,
    input  logic [7:0]        reg_cmd,
    input  logic [15:0]       reg_bytecount,
    input  logic [7:0]        reg_data_in,
    output logic [7:0]        reg_data_out,
    input  logic              reg_read,
    input  logic              reg_write,
    output logic [NUM_CH-1:0] target_reset,
    output logic [NUM_CH-1:0] pulse_busy
);

    // Width register is accessed byte-wise; pad it up to whole bytes.
    localparam int NBYTES = (CNT_W + 7) / 8;
    localparam int WEXT   = NBYTES * 8;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_PULSE = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [NUM_CH-1:0] lvl_q,   lvl_d;
    logic [NUM_CH-1:0] mode_q,  mode_d;
    logic [NUM_CH-1:0] pol_q,   pol_d;
    logic [CNT_W-1:0]  width_q, width_d;

    state_t            state_q [NUM_CH];
    state_t            state_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_d   [NUM_CH];

    logic [NUM_CH-1:0] tr_q,   tr_d;
    logic [NUM_CH-1:0] busy_q, busy_d;

    // -----------------------------------------------------------------------
    // Write decode
    // -----------------------------------------------------------------------
    logic             wr_bc0;
    logic             wr_level;
    logic             wr_mode;
    logic             wr_pol;
    logic             wr_width;
    logic             wr_fire;
    logic [CNT_W-1:0] width_eff;
    logic [WEXT-1:0]  width_ext_q;

    assign wr_bc0   = reg_write && (reg_bytecount == 16'd0);
    assign wr_level = wr_bc0 && (reg_cmd == CMD_LEVEL);
    assign wr_mode  = wr_bc0 && (reg_cmd == CMD_MODE);
    assign wr_pol   = wr_bc0 && (reg_cmd == CMD_POLARITY);
    assign wr_fire  = wr_bc0 && (reg_cmd == CMD_FIRE);
    assign wr_width = reg_write && (reg_cmd == CMD_WIDTH);

    // A zero width still produces a one-cycle pulse.
    assign width_eff   = (width_q == '0) ? CNT_W'(1) : width_q;
    assign width_ext_q = WEXT'(width_q);

    // -----------------------------------------------------------------------
    // Configuration register next-state
    // -----------------------------------------------------------------------
    logic [WEXT-1:0] width_ext_d;

    always_comb begin
        lvl_d       = lvl_q;
        mode_d      = mode_q;
        pol_d       = pol_q;
        width_ext_d = width_ext_q;

        // Only the low NUM_CH data bits map onto channels.
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_level) lvl_d[i]  = reg_data_in[i];
            if (wr_mode)  mode_d[i] = reg_data_in[i];
            if (wr_pol)   pol_d[i]  = reg_data_in[i];
        end

        // Little-endian byte writes; bytes past the register are ignored and
        // padding bits above CNT_W are dropped by the truncation below.
        if (wr_width) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (reg_bytecount == 16'(k)) begin
                    width_ext_d[k*8 +: 8] = reg_data_in;
                end
            end
        end

        width_d = width_ext_d[CNT_W-1:0];
    end

    // -----------------------------------------------------------------------
    // Channel FSM next-state
    // -----------------------------------------------------------------------
    logic [NUM_CH-1:0] fire_hit;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            fire_hit[i] = wr_fire && reg_data_in[i] && mode_q[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];

            case (state_q[i])
                S_IDLE: begin
                    if (fire_hit[i]) begin
                        state_d[i] = S_PULSE;
                        cnt_d[i]   = width_eff;
                    end
                end
                S_PULSE: begin
                    // A fire on the final count wins, so the pin never drops.
                    if (fire_hit[i]) begin
                        cnt_d[i] = width_eff;
                    end else if (cnt_q[i] == CNT_W'(1)) begin
                        state_d[i] = S_IDLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = S_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase

            // Leaving pulse mode aborts any running pulse.
            if (!mode_d[i]) begin
                state_d[i] = S_IDLE;
                cnt_d[i]   = '0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output next-state (pins are registered from the current state)
    // -----------------------------------------------------------------------
    always_comb begin
        tr_d   = '0;
        busy_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            busy_d[i] = (state_q[i] == S_PULSE);
            tr_d[i]   = (mode_q[i] ? (state_q[i] == S_PULSE) : lvl_q[i])
                        ^ pol_q[i];
        end
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_usb) begin
        if (!reset) begin
            lvl_q   <= '0;
            mode_q  <= '0;
            pol_q   <= '0;
            width_q <= CNT_W'(DEFAULT_WIDTH);
            tr_q    <= '0;
            busy_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            lvl_q   <= lvl_d;
            mode_q  <= mode_d;
            pol_q   <= pol_d;
            width_q <= width_d;
            tr_q    <= tr_d;
            busy_q  <= busy_d;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign target_reset = tr_q;
    assign pulse_busy   = busy_q;

    // -----------------------------------------------------------------------
    // Read mux (combinational; busy reflects the state before the edge)
    // -----------------------------------------------------------------------
    always_comb begin
        reg_data_out = 8'h00;
        if (reg_read) begin
            if (reg_cmd == CMD_WIDTH) begin
                for (int k = 0; k < NBYTES; k++) begin
                    if (reg_bytecount == 16'(k)) begin
                        reg_data_out = width_ext_q[k*8 +: 8];
                    end
                end
            end else if (reg_bytecount == 16'd0) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (reg_cmd == CMD_LEVEL)    reg_data_out[i] = lvl_q[i];
                    if (reg_cmd == CMD_MODE)     reg_data_out[i] = mode_q[i];
                    if (reg_cmd == CMD_POLARITY) reg_data_out[i] = pol_q[i];
                    if (reg_cmd == CMD_FIRE)     reg_data_out[i] = (state_q[i] == S_PULSE);
                end
            end
        end
    end

endmodule

// File: tb/tb_target_resetter_multi.sv
// ---------------------------------------------------------------------------
// tb_target_resetter_multi
//
// Directed bench for target_resetter_multi with the default parameters
// (4 channels, 24-bit width, width 1000 after reset). A table of per-cycle
// vectors covers reset, level/polarity and register reads; hand-written
// sequences cover pulse length, retrigger, W=0, abort and reset mid-pulse.
// Inputs are driven at the falling edge and outputs sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_target_resetter_multi;

    localparam logic [7:0] C_LVL  = 8'h30;
    localparam logic [7:0] C_MODE = 8'h31;
    localparam logic [7:0] C_POL  = 8'h32;
    localparam logic [7:0] C_WID  = 8'h33;
    localparam logic [7:0] C_FIRE = 8'h34;

    logic        clk_usb = 1'b0;
    logic        reset;
    logic [7:0]  reg_cmd;
    logic [15:0] reg_bytecount;
    logic [7:0]  reg_data_in;
    logic [7:0]  reg_data_out;
    logic        reg_read;
    logic        reg_write;
    logic [3:0]  target_reset;
    logic [3:0]  pulse_busy;

    int n_cmp = 0;
    int n_bad = 0;

    target_resetter_multi dut (
        .clk_usb       (clk_usb),
        .reset         (reset),
        .reg_cmd       (reg_cmd),
        .reg_bytecount (reg_bytecount),
        .reg_data_in   (reg_data_in),
        .reg_data_out  (reg_data_out),
        .reg_read      (reg_read),
        .reg_write     (reg_write),
        .target_reset  (target_reset),
        .pulse_busy    (pulse_busy)
    );

    always #5 clk_usb = ~clk_usb;

    typedef struct {
        logic        rst;   // value driven on reset (active low)
        logic        wr;
        logic        rd;
        logic [7:0]  cmd;
        logic [15:0] bc;
        logic [7:0]  din;
        logic        chk;   // compare outputs on this row
        logic [3:0]  tr;    // expected target_reset before this row's edge
        logic [3:0]  busy;
        logic [7:0]  dout;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic wr, input logic rd,
                                input logic [7:0] cmd, input logic [15:0] bc,
                                input logic [7:0] din, input logic chk,
                                input logic [3:0] tr, input logic [3:0] busy,
                                input logic [7:0] dout);
        vec_t v;
        v.rst = rst; v.wr = wr; v.rd = rd; v.cmd = cmd; v.bc = bc; v.din = din;
        v.chk = chk; v.tr = tr; v.busy = busy; v.dout = dout;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drv(input logic r, input logic w, input logic rd,
                       input logic [7:0] c, input logic [15:0] b, input logic [7:0] d);
        @(negedge clk_usb);
        reset = r; reg_write = w; reg_read = rd;
        reg_cmd = c; reg_bytecount = b; reg_data_in = d;
        #1;
    endtask

    // Observes channel 1 for n cycles after a fire edge, while reading the
    // busy mask. Optionally injects one write at sample inj_at.
    task automatic run_pulse(input string name, input int n, input int inj_at,
                             input logic [7:0] inj_cmd, input logic [7:0] inj_din,
                             input int exp_len);
        int hi = 0, busy_hi = 0, first = -1, last = -1, other_bad = 0;
        logic [7:0] d0 = 8'hxx, dlast = 8'hxx;
        for (int j = 0; j < n; j++) begin
            if (j == inj_at) drv(1'b1, 1'b1, 1'b1, inj_cmd, 16'd0, inj_din);
            else             drv(1'b1, 1'b0, 1'b1, C_FIRE, 16'd0, 8'h00);
            if (target_reset[1]) begin
                hi++;
                if (first < 0) first = j;
                last = j;
            end
            if (pulse_busy[1]) busy_hi++;
            if ((target_reset & 4'b1101) != 4'b0101) other_bad++;
            if (j == 0)     d0 = reg_data_out;
            if (j == n - 1) dlast = reg_data_out;
        end
        check({name, " high cycles"}, hi, exp_len);
        check({name, " first high"}, first, 1);
        check({name, " contiguous span"}, last - first + 1, exp_len);
        check({name, " busy cycles"}, busy_hi, exp_len);
        check({name, " other channels"}, other_bad, 0);
        check({name, " busy read during"}, d0, 8'h02);
        check({name, " busy read after"}, dlast, 8'h00);
    endtask

    initial begin
        reset = 1'b0; reg_write = 1'b0; reg_read = 1'b0;
        reg_cmd = 8'h00; reg_bytecount = 16'd0; reg_data_in = 8'h00;

        //                rst wr rd cmd     bc  din    chk tr     busy   dout
        vecs.push_back(mk(0, 0, 0, 8'h00,  0, 8'h00, 0, 4'h0, 4'h0, 8'h00));
        vecs.push_back(mk(0, 0, 0, 8'h00,  0, 8'h00, 1, 4'h0, 4'h0, 8'h00));
        vecs.push_back(mk(1, 0, 1, C_WID,  0, 8'h00, 1, 4'h0, 4'h0, 8'hE8));
        vecs.push_back(mk(1, 0, 1, C_WID,  1, 8'h00, 1, 4'h0, 4'h0, 8'h03));
        vecs.push_back(mk(1, 0, 1, C_WID,  2, 8'h00, 1, 4'h0, 4'h0, 8'h00));
        vecs.push_back(mk(1, 0, 1, C_WID,  3, 8'h00, 1, 4'h0, 4'h0, 8'h00));
        vecs.push_back(mk(1, 1, 0, C_LVL,  0, 8'h05, 1, 4'h0, 4'h0, 8'h00));
        vecs.push_back(mk(1, 0, 0, 8'h00,  0, 8'h00, 1, 4'h0, 4'h0, 8'h00));
        vecs.push_back(mk(1, 1, 0, C_POL,  0, 8'h0F, 1, 4'h5, 4'h0, 8'h00));
        vecs.push_back(mk(1, 0, 1, C_LVL,  0, 8'h00, 1, 4'h5, 4'h0, 8'h05));
        vecs.push_back(mk(1, 0, 1, C_POL,  0, 8'h00, 1, 4'hA, 4'h0, 8'h0F));
        vecs.push_back(mk(1, 0, 1, C_LVL,  1, 8'h00, 1, 4'hA, 4'h0, 8'h00));
        vecs.push_back(mk(1, 1, 0, C_LVL,  1, 8'hFF, 1, 4'hA, 4'h0, 8'h00));
        vecs.push_back(mk(1, 0, 1, C_LVL,  0, 8'h00, 1, 4'hA, 4'h0, 8'h05));
        vecs.push_back(mk(1, 1, 0, 8'h40,  0, 8'hFF, 1, 4'hA, 4'h0, 8'h00));
        vecs.push_back(mk(1, 1, 0, C_POL,  0, 8'h00, 1, 4'hA, 4'h0, 8'h00));
        vecs.push_back(mk(1, 0, 0, 8'h00,  0, 8'h00, 1, 4'hA, 4'h0, 8'h00));
        vecs.push_back(mk(1, 0, 1, C_MODE, 0, 8'h00, 1, 4'h5, 4'h0, 8'h00));
        vecs.push_back(mk(1, 0, 0, C_LVL,  0, 8'h00, 1, 4'h5, 4'h0, 8'h00));

        foreach (vecs[i]) begin
            drv(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].cmd, vecs[i].bc, vecs[i].din);
            if (vecs[i].chk) begin
                check($sformatf("vec%0d target_reset", i), target_reset, vecs[i].tr);
                check($sformatf("vec%0d pulse_busy", i), pulse_busy, vecs[i].busy);
                check($sformatf("vec%0d reg_data_out", i), reg_data_out, vecs[i].dout);
            end
        end

        // Pulse width 10 on channel 1; channel 0 in level mode ignores fire.
        drv(1, 1, 0, C_WID, 0, 8'h0A);
        drv(1, 1, 0, C_WID, 1, 8'h00);
        drv(1, 1, 0, C_WID, 2, 8'h00);
        drv(1, 0, 1, C_WID, 0, 8'h00);
        check("width readback", reg_data_out, 8'h0A);
        drv(1, 1, 0, C_MODE, 0, 8'h02);
        drv(1, 1, 0, C_FIRE, 0, 8'h03);
        run_pulse("pulse10", 20, -1, 8'h00, 8'h00, 10);

        // Retrigger six cycles after the first fire.
        drv(1, 1, 0, C_FIRE, 0, 8'h02);
        run_pulse("retrig", 30, 5, C_FIRE, 8'h02, 16);

        // Width zero behaves as one.
        drv(1, 1, 0, C_WID, 0, 8'h00);
        drv(1, 1, 0, C_FIRE, 0, 8'h02);
        run_pulse("w0", 6, -1, 8'h00, 8'h00, 1);

        // Abort by clearing mode mid-pulse.
        drv(1, 1, 0, C_WID, 0, 8'h0A);
        drv(1, 1, 0, C_FIRE, 0, 8'h02);
        run_pulse("abort", 10, 3, C_MODE, 8'h00, 4);

        // Reset mid-pulse, with a simultaneous level write that must be lost.
        drv(1, 1, 0, C_MODE, 0, 8'h02);
        drv(1, 1, 0, C_FIRE, 0, 8'h02);
        drv(1, 0, 0, 8'h00, 0, 8'h00);
        drv(1, 0, 0, 8'h00, 0, 8'h00);
        drv(1, 0, 0, 8'h00, 0, 8'h00);
        check("pre-reset busy", pulse_busy, 4'b0010);
        drv(0, 1, 0, C_LVL, 0, 8'hFF);
        check("pre-reset pins", target_reset, 4'b0111);
        drv(1, 0, 1, C_WID, 0, 8'h00);
        check("post-reset pins", target_reset, 4'b0000);
        check("post-reset busy", pulse_busy, 4'b0000);
        check("post-reset width b0", reg_data_out, 8'hE8);
        drv(1, 0, 1, C_WID, 1, 8'h00);
        check("post-reset width b1", reg_data_out, 8'h03);
        drv(1, 0, 1, C_LVL, 0, 8'h00);
        check("post-reset level", reg_data_out, 8'h00);
        drv(1, 0, 1, C_FIRE, 0, 8'h00);
        check("post-reset busy read", reg_data_out, 8'h00);
        check("post-reset pins later", target_reset, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/target_resetter_multi.md
# target_resetter_multi

Parametrised, multi-channel successor to the single-bit target reset register. It drives NUM_CH independent target reset lines from the host serial register interface. Each channel runs in level mode (host-held) or pulse mode (self-timed, W clk_usb cycles), with programmable output polarity. It sits on the clk_usb register bus alongside the other command-decoded peripherals.

## Interface
Parameters:
- NUM_CH, 4, number of reset channels (1..8)
- CNT_W, 24, pulse-width counter width in bits (8..32)
- DEFAULT_WIDTH, 1000, pulse width loaded at reset (cycles)
- CMD_LEVEL, 8'h30, command code: per-channel level bits
- CMD_MODE, 8'h31, command code: per-channel mode bits (1 = pulse)
- CMD_POLARITY, 8'h32, command code: per-channel polarity bits (1 = active-low pin)
- CMD_WIDTH, 8'h33, command code: pulse width, little-endian multi-byte
- CMD_FIRE, 8'h34, command code: write = fire mask, read = busy mask

Ports:
- clk_usb  in  1  sole clock
- reset  in  1  synchronous, active-low reset
- reg_cmd  in  8  command code
- reg_bytecount  in  16  byte index within the current command
- reg_data_in  in  8  write data byte
- reg_data_out  out  8  read data byte, combinational
- reg_read  in  1  read strobe
- reg_write  in  1  write strobe, one byte per asserted cycle
- target_reset  out  NUM_CH  registered reset pins
- pulse_busy  out  NUM_CH  registered, 1 while the channel's pulse is running

## Operation
- Registers, all cleared by reset:
  - lvl[NUM_CH], mode[NUM_CH], pol[NUM_CH], all reset to 0.
  - width[CNT_W], resets to DEFAULT_WIDTH.
- Writes act on the clk_usb edge where reg_write=1.
  - CMD_LEVEL, CMD_MODE and CMD_POLARITY take effect only at reg_bytecount==0. Bits at index NUM_CH and above are ignored.
  - CMD_WIDTH: reg_bytecount=k writes width[8k+7:8k] for k < ceil(CNT_W/8). Higher k is ignored. Bits above CNT_W are dropped.
  - CMD_FIRE at bytecount 0: for each channel i with reg_data_in[i]=1 and mode[i]=1, load cnt_i = max(width,1) and enter PULSE. Channels in level mode ignore fire.
  - Unknown commands are ignored.
- Per-channel FSM:
  - IDLE: stays in IDLE until a fire.
  - PULSE: cnt_i decrements each cycle. cnt_i==1 with no fire goes to IDLE.
  - Fire while in PULSE retriggers: cnt_i reloads and the channel stays in PULSE.
  - A write clearing mode[i] while in PULSE aborts: go to IDLE, cnt_i=0.
- Width writes during a running pulse do not alter cnt_i. They apply to the next fire only.
- Active term:
  - act_i = lvl[i] in level mode.
  - act_i = (state_i==PULSE) in pulse mode.
- Outputs, registered each edge:
  - target_reset[i] <= act_i ^ pol[i]
  - pulse_busy[i] <= (state_i==PULSE)
- Reads (reg_read=1):
  - reg_data_out = zero-extended register for CMD_LEVEL/MODE/POLARITY at bytecount 0.
  - CMD_WIDTH returns byte k.
  - CMD_FIRE returns the busy mask at bytecount 0.
  - Any other command or bytecount returns 0. reg_read=0 also returns 0.
- Reset (reset=0 at an edge):
  - All registers go to reset values, all FSMs to IDLE, cnt_i = 0.
  - target_reset = 0 and pulse_busy = 0 after that edge.
  - Reset overrides any simultaneous write.
  - Reset mid-pulse terminates the pulse immediately.

## Timing
- Level write sampled at edge E0: target_reset changes at E1 (one-cycle register latency).
- Polarity write at E0: the pin inverts at E1.
- Fire at E0 with width W ≥ 1:
  - target_reset and pulse_busy assert at E1 and deassert at E1+W.
  - The pulse is exactly W cycles. W=0 behaves as W=1.
- Retrigger at edge Er during PULSE: deassert occurs at Er+1+W. No gap or glitch on the pin.
- Fire on the same edge the counter reaches 1: treated as a retrigger, so the pin stays asserted.
- Mode clear at E0 during PULSE: the pin deasserts at E1.
- Channels are fully independent. Simultaneous fire of several channels yields pulses aligned to the same cycle.
- reg_data_out is combinational from reg_cmd, reg_bytecount, reg_read and the registers. Busy read at E0 reflects the state before E0.

## Test plan
- Reset sequence: reset=0 for 2 cycles then 1. Expect target_reset=0, pulse_busy=0. Reading CMD_WIDTH bytes 0/1/2 returns 8'hE8, 8'h03, 8'h00.
- Level and polarity: write CMD_LEVEL=8'h05. Expect target_reset=4'b0101 one cycle later. Then write CMD_POLARITY=8'h0F. Expect 4'b1010 one cycle later. Reading CMD_LEVEL returns 8'h05.
- Pulse width: write CMD_WIDTH bytes 8'h0A, 8'h00, 8'h00; write CMD_MODE=8'h02; write CMD_FIRE=8'h03.
  - Channel 1 high for exactly 10 cycles starting the cycle after fire.
  - Channel 0 is unaffected (level mode).
  - The CMD_FIRE read returns 8'h02 during the pulse and 8'h00 after.
- Retrigger and W=0: with width 10, fire channel 1, then fire again 6 cycles later. Expect 16 contiguous high cycles. Set width 0 and fire. Expect exactly 1 high cycle.
- Abort and reset mid-pulse:
  - During a pulse, write CMD_MODE=8'h00. Pin and busy drop the next cycle.
  - Repeat with reset=0 mid-pulse. All outputs 0 after that edge, and width reads back 1000.
